// File: rtl/writeback_arbiter.sv
// Writeback arbiter: LSU/MDU/ALU result arbitration, register-file write port and pending-write scoreboard.
// Optional bypass of the committing result to the issue stage under `WB_FORWARD_EN.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mdu_valid,
  input  logic [4:0]            mdu_rd,
  input  logic [DATA_WIDTH-1:0] mdu_data,
  output logic                  mdu_ready,
  input  logic                  lsu_valid,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic [4:0]            int_rd_addr,
  output logic [DATA_WIDTH-1:0] int_rd_data,
  output logic                  int_rd_write,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  output logic                  iss_ready,
  input  logic [4:0]            iss_rs1,
  input  logic [4:0]            iss_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data,
  input  logic                  flush
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]         starve_q, starve_d;
  logic                  wr_q, wr_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           pend_q, pend_d;

  logic                  gnt_alu, gnt_mdu, gnt_lsu;
  logic                  starved;
  logic                  xfer;
  logic [4:0]            sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  iss_fwd;
  logic                  alloc;

  assign starved = alu_valid && (starve_q == LIMIT);

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mdu = 1'b0;
    gnt_lsu = 1'b0;
    if (!reset) begin
      priority case (1'b1)
        starved:   gnt_alu = 1'b1;
        lsu_valid: gnt_lsu = 1'b1;
        mdu_valid: gnt_mdu = 1'b1;
        alu_valid: gnt_alu = 1'b1;
        default:   ;
      endcase
    end
  end

  assign alu_ready = gnt_alu;
  assign mdu_ready = gnt_mdu;
  assign lsu_ready = gnt_lsu;
  assign xfer      = gnt_alu || gnt_mdu || gnt_lsu;

  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    if (gnt_lsu) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end else if (gnt_mdu) begin
      sel_rd   = mdu_rd;
      sel_data = mdu_data;
    end
  end

  // x0 results are consumed but never reach the register file
  always_comb begin
    wr_d   = xfer && (sel_rd != 5'd0);
    addr_d = addr_q;
    data_d = data_q;
    if (wr_d) begin
      addr_d = sel_rd;
      data_d = sel_data;
    end
  end

  always_comb begin
    starve_d = '0;
    if (alu_valid && !gnt_alu)
      starve_d = starve_q + CW'(1);
  end

  assign int_rd_write = wr_q;
  assign int_rd_addr  = addr_q;
  assign int_rd_data  = data_q;

`ifdef WB_FORWARD_EN
  assign fwd_rs1_hit  = wr_q && (iss_rs1 != 5'd0) && (addr_q == iss_rs1);
  assign fwd_rs2_hit  = wr_q && (iss_rs2 != 5'd0) && (addr_q == iss_rs2);
  assign fwd_rs1_data = fwd_rs1_hit ? data_q : '0;
  assign fwd_rs2_data = fwd_rs2_hit ? data_q : '0;
  assign iss_fwd      = wr_q && (addr_q == iss_rd);
`else
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
  assign iss_fwd      = 1'b0;
`endif

  assign rs1_busy = (iss_rs1 != 5'd0) && pend_q[iss_rs1] && !fwd_rs1_hit;
  assign rs2_busy = (iss_rs2 != 5'd0) && pend_q[iss_rs2] && !fwd_rs2_hit;

  assign iss_ready = !reset &&
    ((iss_rd == 5'd0) || !pend_q[iss_rd] || iss_fwd);

  assign alloc = iss_valid && iss_ready && (iss_rd != 5'd0);

  // set after clear so a same-cycle reallocation stays reserved
  always_comb begin
    pend_d = pend_q;
    if (wr_q)
      pend_d[addr_q] = 1'b0;
    if (alloc)
      pend_d[iss_rd] = 1'b1;
    if (flush)
      pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
    end
  end

endmodule
